sram_axi_bridge: RTL and testbench
==================================

SRAM_AXI_BRIDGE -- requirements
Module: sram_axi_bridge

Interface
REQ-001 SHALL have parameters: INST_ID, 4'd0, ARID for instruction reads; DATA_ID, 4'd1, ARID/AWID for data transactions.
REQ-002 SHALL have ports `clk` (input, 1, sole clock, rising edge) and `resetn` (input, 1, asynchronous active-low reset).
REQ-003 SHALL have inst-port inputs `inst_req` (1) and `inst_addr` (32), and outputs `inst_rdata` (32), `inst_addr_ok` (1) and `inst_data_ok` (1); these form an SRAM-like read-only slave.
REQ-004 SHALL have data-port inputs `data_req` (1), `data_wr` (1), `data_wstrb` (4), `data_addr` (32), `data_size` (3) and `data_wdata` (32), and outputs `data_rdata` (32), `data_addr_ok` (1) and `data_data_ok` (1).
REQ-005 SHALL have AXI read master ports:
- `arid` (4), `araddr` (32), `arlen` (8), `arsize` (3), `arburst` (2) and `arvalid` outputs; `arready` input.
- `rid` (4), `rdata` (32), `rresp` (2), `rlast` (1) and `rvalid` inputs; `rready` output.
REQ-006 SHALL have AXI write master ports:
- `awid` (4), `awaddr` (32), `awlen` (8), `awsize` (3), `awburst` (2) and `awvalid` outputs; `awready` input.
- `wdata` (32), `wstrb` (4), `wlast` (1) and `wvalid` outputs; `wready` input.
- `bid` (4), `bresp` (2) and `bvalid` inputs; `bready` output.

Function
REQ-007 SHALL issue only single-beat transactions: `arlen`/`awlen` = 0, `arburst`/`awburst` = 2'b01, `wlast` = 1.
REQ-008 SHALL run a read FSM with states R_IDLE → R_AR → R_R → R_IDLE:
- R_IDLE → R_AR on a granted read.
- R_AR → R_R on `arvalid` && `arready`.
- R_R → R_IDLE on `rvalid` && `rready`.
REQ-009 SHALL run a write FSM with states W_IDLE → W_REQ → W_B → W_IDLE:
- W_REQ drops `awvalid` and `wvalid` independently on their own handshakes.
- W_REQ → W_B once both handshakes are done, including the same cycle.
- W_B → W_IDLE on `bvalid` && `bready`.
REQ-010 SHALL allow at most one outstanding data-port transaction, tracked by a data-busy flag, plus at most one outstanding read overall.
REQ-011 SHALL define the accept conditions:
- Data read: `data_addr_ok` = `data_req` && !`data_wr` && !data-busy && R_IDLE && data wins arbitration.
- Data write: `data_addr_ok` = `data_req` && `data_wr` && !data-busy && W_IDLE.
- Inst read: `inst_addr_ok` = `inst_req` && R_IDLE && inst wins arbitration.
All accept conditions are combinational, same cycle as the request.
REQ-012 SHALL register the address, size, wstrb, wdata and ID on accept; the first cycle `arvalid`/`awvalid`/`wvalid` is high is the cycle after accept.
REQ-013 SHALL drive `arsize` = captured `data_size[1:0]` for data reads and 3'd2 for inst reads; `awsize` = captured `data_size[1:0]`; `wstrb` = captured `data_wstrb`.
REQ-014 SHALL hold `rready` = 1 only in R_R and `bready` = 1 only in W_B.
REQ-015 SHALL route read responses combinationally:
- `inst_data_ok` = `rvalid` && `rready` && `rid` == INST_ID.
- `data_data_ok` = `rvalid` && `rready` && `rid` == DATA_ID, or `bvalid` && `bready`.
- `inst_rdata` = `data_rdata` = `rdata`.
REQ-016 SHALL complete a data read and a data write response in the same cycle only if they belong to different ports; this is guaranteed by REQ-010.
REQ-017 SHALL ignore `rresp`/`bresp`; error responses complete normally.
REQ-018 SHALL accept a data write and an inst read in the same cycle when both FSMs are idle.
REQ-019 SHALL keep the inst port usable while a data write is outstanding.

Reset
REQ-020 SHALL, on `resetn` low at any time, immediately force R_IDLE, W_IDLE, data-busy = 0, all valid/ready outputs = 0, all registered address/data = 0 and round-robin pointer = inst-last.
REQ-021 SHALL abandon in-flight transactions on reset; the AXI slave shares `resetn`.

Configuration
REQ-022 SHALL support the macro `BRIDGE_DATA_PRIO_EN`:
- Defined: a data read always wins over an inst read.
- Undefined: round-robin; when both request, the port not granted last wins, and the pointer updates on every read grant.

Verification
REQ-023 Inst read 0xBFC00000, `arready` = 1, `rvalid` 2 cycles later with 0x3C010001:
- `inst_addr_ok` same cycle; `arvalid`/`arid` = 0 next cycle.
- `inst_data_ok` pulse with `inst_rdata` = 0x3C010001.
REQ-024 Data write 0x80000010, wstrb 4'b0011, size 1, `awready` 1 cycle before `wready`:
- `awvalid` drops first; `bready` rises after the W handshake.
- `data_data_ok` on `bvalid`.
REQ-025 Simultaneous inst read and data read with `BRIDGE_DATA_PRIO_EN` defined: data granted first; without it, after a prior inst grant, data granted.
REQ-026 Data write outstanding, second `data_req` (read): `data_addr_ok` stays 0 until the B handshake cycle, then it is accepted.
REQ-027 `resetn` asserted while in R_R: `rready`/`arvalid` = 0 immediately; a new inst read after release completes normally.
REQ-028 `rresp` = 2'b10 on a data read: `data_data_ok` still pulses once, FSM returns to R_IDLE.

Source files
------------

// File: rtl/sram_axi_bridge.sv
`default_nettype none
// ============================================================================
// sram_axi_bridge : SRAM-like inst/data slave ports to single-beat AXI master.
// Macro BRIDGE_DATA_PRIO_EN gives data reads fixed priority over inst reads.
// Revision        : 1.0
// ============================================================================
module sram_axi_bridge #(
   parameter logic [3:0] INST_ID = 4'd0,
   parameter logic [3:0] DATA_ID = 4'd1
) (
   input  logic        clk,
   input  logic        resetn,
   // inst port
   input  logic        inst_req,
   input  logic [31:0] inst_addr,
   output logic [31:0] inst_rdata,
   output logic        inst_addr_ok,
   output logic        inst_data_ok,
   // data port
   input  logic        data_req,
   input  logic        data_wr,
   input  logic [3:0]  data_wstrb,
   input  logic [31:0] data_addr,
   input  logic [2:0]  data_size,
   input  logic [31:0] data_wdata,
   output logic [31:0] data_rdata,
   output logic        data_addr_ok,
   output logic        data_data_ok,
   // AXI read
   output logic [3:0]  arid,
   output logic [31:0] araddr,
   output logic [7:0]  arlen,
   output logic [2:0]  arsize,
   output logic [1:0]  arburst,
   output logic        arvalid,
   input  logic        arready,
   input  logic [3:0]  rid,
   input  logic [31:0] rdata,
   input  logic [1:0]  rresp,
   input  logic        rlast,
   input  logic        rvalid,
   output logic        rready,
   // AXI write
   output logic [3:0]  awid,
   output logic [31:0] awaddr,
   output logic [7:0]  awlen,
   output logic [2:0]  awsize,
   output logic [1:0]  awburst,
   output logic        awvalid,
   input  logic        awready,
   output logic [31:0] wdata,
   output logic [3:0]  wstrb,
   output logic        wlast,
   output logic        wvalid,
   input  logic        wready,
   input  logic [3:0]  bid,
   input  logic [1:0]  bresp,
   input  logic        bvalid,
   output logic        bready
);

   typedef enum logic [1:0] {R_IDLE = 2'd0, R_AR = 2'd1, R_R = 2'd2} r_state_t;
   typedef enum logic [1:0] {W_IDLE = 2'd0, W_REQ = 2'd1, W_B = 2'd2} w_state_t;

   r_state_t    r_state_q, r_state_d;
   w_state_t    w_state_q, w_state_d;
   logic        data_busy_q, data_busy_d;
   logic [31:0] araddr_q, araddr_d;
   logic [2:0]  arsize_q, arsize_d;
   logic [3:0]  arid_q, arid_d;
   logic [31:0] awaddr_q, awaddr_d;
   logic [2:0]  awsize_q, awsize_d;
   logic [31:0] wdata_q, wdata_d;
   logic [3:0]  wstrb_q, wstrb_d;
   logic        awvalid_q, awvalid_d;
   logic        wvalid_q, wvalid_d;

   logic data_rd_req, data_wins, data_rd_grant, data_wr_grant, inst_grant;
   logic r_hs, b_hs;
   logic unused_inputs;

   assign unused_inputs = ^{rresp, bresp, bid, rlast, data_size[2]};

   assign data_rd_req   = data_req && !data_wr && !data_busy_q && (r_state_q == R_IDLE);
   assign data_rd_grant = data_rd_req && data_wins;
   assign inst_grant    = inst_req && (r_state_q == R_IDLE) && !data_rd_grant;
   assign data_wr_grant = data_req && data_wr && !data_busy_q && (w_state_q == W_IDLE);

`ifdef BRIDGE_DATA_PRIO_EN
   assign data_wins = 1'b1;
`else
   // Round-robin: on a tie the port that was not granted last wins.
   logic last_inst_q, last_inst_d;

   assign data_wins = !inst_req || last_inst_q;

   always_comb begin
      last_inst_d = last_inst_q;
      if (data_rd_grant)
         last_inst_d = 1'b0;
      else if (inst_grant)
         last_inst_d = 1'b1;
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn)
         last_inst_q <= 1'b1;
      else
         last_inst_q <= last_inst_d;
   end
`endif

   assign r_hs = rvalid && rready;
   assign b_hs = bvalid && bready;

   always_comb begin
      r_state_d = r_state_q;
      araddr_d  = araddr_q;
      arsize_d  = arsize_q;
      arid_d    = arid_q;
      case (r_state_q)
         R_IDLE: begin
            if (data_rd_grant) begin
               r_state_d = R_AR;
               araddr_d  = data_addr;
               arsize_d  = {1'b0, data_size[1:0]};
               arid_d    = DATA_ID;
            end else if (inst_grant) begin
               r_state_d = R_AR;
               araddr_d  = inst_addr;
               arsize_d  = 3'd2;
               arid_d    = INST_ID;
            end
         end
         R_AR:    if (arready) r_state_d = R_R;
         R_R:     if (rvalid)  r_state_d = R_IDLE;
         default: r_state_d = R_IDLE;
      endcase
   end

   // AW and W retire independently; leave W_REQ once both have gone.
   always_comb begin
      w_state_d = w_state_q;
      awaddr_d  = awaddr_q;
      awsize_d  = awsize_q;
      wdata_d   = wdata_q;
      wstrb_d   = wstrb_q;
      awvalid_d = awvalid_q;
      wvalid_d  = wvalid_q;
      case (w_state_q)
         W_IDLE: begin
            if (data_wr_grant) begin
               w_state_d = W_REQ;
               awaddr_d  = data_addr;
               awsize_d  = {1'b0, data_size[1:0]};
               wdata_d   = data_wdata;
               wstrb_d   = data_wstrb;
               awvalid_d = 1'b1;
               wvalid_d  = 1'b1;
            end
         end
         W_REQ: begin
            if (awready) awvalid_d = 1'b0;
            if (wready)  wvalid_d  = 1'b0;
            if ((!awvalid_q || awready) && (!wvalid_q || wready))
               w_state_d = W_B;
         end
         W_B:     if (bvalid) w_state_d = W_IDLE;
         default: w_state_d = W_IDLE;
      endcase
   end

   always_comb begin
      data_busy_d = data_busy_q;
      if (data_rd_grant || data_wr_grant)
         data_busy_d = 1'b1;
      else if (data_data_ok)
         data_busy_d = 1'b0;
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         r_state_q   <= R_IDLE;
         w_state_q   <= W_IDLE;
         data_busy_q <= 1'b0;
         araddr_q    <= 32'd0;
         arsize_q    <= 3'd0;
         arid_q      <= 4'd0;
         awaddr_q    <= 32'd0;
         awsize_q    <= 3'd0;
         wdata_q     <= 32'd0;
         wstrb_q     <= 4'd0;
         awvalid_q   <= 1'b0;
         wvalid_q    <= 1'b0;
      end else begin
         r_state_q   <= r_state_d;
         w_state_q   <= w_state_d;
         data_busy_q <= data_busy_d;
         araddr_q    <= araddr_d;
         arsize_q    <= arsize_d;
         arid_q      <= arid_d;
         awaddr_q    <= awaddr_d;
         awsize_q    <= awsize_d;
         wdata_q     <= wdata_d;
         wstrb_q     <= wstrb_d;
         awvalid_q   <= awvalid_d;
         wvalid_q    <= wvalid_d;
      end
   end

   assign inst_addr_ok = inst_grant;
   assign data_addr_ok = data_rd_grant || data_wr_grant;
   assign inst_data_ok = r_hs && (rid == INST_ID);
   assign data_data_ok = (r_hs && (rid == DATA_ID)) || b_hs;
   assign inst_rdata   = rdata;
   assign data_rdata   = rdata;

   assign arid    = arid_q;
   assign araddr  = araddr_q;
   assign arlen   = 8'd0;
   assign arsize  = arsize_q;
   assign arburst = 2'b01;
   assign arvalid = (r_state_q == R_AR);
   assign rready  = (r_state_q == R_R);

   assign awid    = DATA_ID;
   assign awaddr  = awaddr_q;
   assign awlen   = 8'd0;
   assign awsize  = awsize_q;
   assign awburst = 2'b01;
   assign awvalid = awvalid_q;
   assign wdata   = wdata_q;
   assign wstrb   = wstrb_q;
   assign wlast   = 1'b1;
   assign wvalid  = wvalid_q;
   assign bready  = (w_state_q == W_B);

endmodule
`default_nettype wire

// File: tb/tb_sram_axi_bridge.sv
`default_nettype none
// ============================================================================
// tb_sram_axi_bridge : directed + randomized bench for sram_axi_bridge.
// Revision           : 1.0
// ============================================================================
module tb_sram_axi_bridge;
   localparam logic [31:0] RD_XOR = 32'h5A5A_0F0F;

   logic clk = 1'b0;
   logic resetn = 1'b0;
   always #5 clk = ~clk;

   logic        inst_req = 0, data_req = 0, data_wr = 0;
   logic [31:0] inst_addr = 0, data_addr = 0, data_wdata = 0;
   logic [3:0]  data_wstrb = 0;
   logic [2:0]  data_size = 0;
   logic [31:0] inst_rdata, data_rdata;
   logic        inst_addr_ok, inst_data_ok, data_addr_ok, data_data_ok;
   logic [3:0]  arid, awid, rid, bid;
   logic [31:0] araddr, awaddr, rdata, wdata;
   logic [7:0]  arlen, awlen;
   logic [2:0]  arsize, awsize;
   logic [1:0]  arburst, awburst, rresp, bresp;
   logic        arvalid, arready, rlast, rvalid, rready;
   logic        awvalid, awready, wvalid, wready, wlast, bvalid, bready;
   logic [3:0]  wstrb;

   // directed slave
   logic        d_arready = 0, d_rvalid = 0, d_awready = 0, d_wready = 0, d_bvalid = 0;
   logic [3:0]  d_rid = 0, d_bid = 0;
   logic [31:0] d_rdata = 0;
   logic [1:0]  d_rresp = 0;
   // random slave
   logic        auto_en = 0;
   logic        a_arready = 0, a_rvalid = 0, a_awready = 0, a_wready = 0, a_bvalid = 0;
   logic [3:0]  a_rid = 0, a_bid = 0, a_id = 0, a_wid = 0;
   logic [31:0] a_rdata = 0, a_addr = 0;
   logic [1:0]  a_rresp = 0, a_bresp = 0;
   logic        a_rd_pend = 0, a_aw_seen = 0, a_w_seen = 0;

   assign arready = auto_en ? a_arready : d_arready;
   assign rvalid  = auto_en ? a_rvalid  : d_rvalid;
   assign rid     = auto_en ? a_rid     : d_rid;
   assign rdata   = auto_en ? a_rdata   : d_rdata;
   assign rresp   = auto_en ? a_rresp   : d_rresp;
   assign rlast   = 1'b1;
   assign awready = auto_en ? a_awready : d_awready;
   assign wready  = auto_en ? a_wready  : d_wready;
   assign bvalid  = auto_en ? a_bvalid  : d_bvalid;
   assign bid     = auto_en ? a_bid     : d_bid;
   assign bresp   = auto_en ? a_bresp   : 2'b00;

   sram_axi_bridge dut (
      .clk(clk), .resetn(resetn),
      .inst_req(inst_req), .inst_addr(inst_addr), .inst_rdata(inst_rdata),
      .inst_addr_ok(inst_addr_ok), .inst_data_ok(inst_data_ok),
      .data_req(data_req), .data_wr(data_wr), .data_wstrb(data_wstrb), .data_addr(data_addr),
      .data_size(data_size), .data_wdata(data_wdata), .data_rdata(data_rdata),
      .data_addr_ok(data_addr_ok), .data_data_ok(data_data_ok),
      .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
      .arvalid(arvalid), .arready(arready),
      .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready),
      .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst),
      .awvalid(awvalid), .awready(awready),
      .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
      .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready)
   );

   // Randomly stalling AXI slave; read data is a fixed function of the address.
   always @(posedge clk) begin
      if (auto_en) begin
         a_arready <= 1'($urandom_range(0, 1));
         a_awready <= 1'($urandom_range(0, 1));
         a_wready  <= 1'($urandom_range(0, 1));
         if (arvalid && arready) begin
            a_rd_pend <= 1'b1;
            a_addr    <= araddr;
            a_id      <= arid;
         end
         if (rvalid && rready)
            a_rvalid <= 1'b0;
         else if (a_rd_pend && !a_rvalid && $urandom_range(0, 2) == 0) begin
            a_rvalid  <= 1'b1;
            a_rid     <= a_id;
            a_rdata   <= a_addr ^ RD_XOR;
            a_rresp   <= 2'($urandom_range(0, 3));
            a_rd_pend <= 1'b0;
         end
         if (awvalid && awready) begin
            a_aw_seen <= 1'b1;
            a_wid     <= awid;
         end
         if (wvalid && wready)
            a_w_seen <= 1'b1;
         if (bvalid && bready)
            a_bvalid <= 1'b0;
         else if (a_aw_seen && a_w_seen && !a_bvalid && $urandom_range(0, 2) == 0) begin
            a_bvalid  <= 1'b1;
            a_bid     <= a_wid;
            a_bresp   <= 2'($urandom_range(0, 3));
            a_aw_seen <= 1'b0;
            a_w_seen  <= 1'b0;
         end
      end
   end

   int checks = 0;
   int errors = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Completes a read already accepted this cycle: AR next cycle, R two cycles after AR.
   task automatic serve_read(input logic [3:0] id, input logic [31:0] addr, input logic [2:0] size,
                             input logic [31:0] rd, input logic [1:0] resp, input string tag);
      @(negedge clk);
      inst_req = 0; data_req = 0; d_arready = 1;
      #1;
      chk({tag, "_arvalid"}, arvalid, 1);
      chk({tag, "_arid"}, arid, id);
      chk({tag, "_araddr"}, araddr, addr);
      chk({tag, "_arsize"}, arsize, size);
      chk({tag, "_arlen_burst"}, {arlen, arburst}, {8'd0, 2'b01});
      @(negedge clk);
      d_arready = 0;
      #1;
      chk({tag, "_rready_arvalid"}, {rready, arvalid}, 2'b10);
      @(negedge clk);
      d_rvalid = 1; d_rid = id; d_rdata = rd; d_rresp = resp;
      #1;
      chk({tag, "_data_ok"}, {inst_data_ok, data_data_ok}, (id == 4'd0) ? 2'b10 : 2'b01);
      chk({tag, "_rdata"}, (id == 4'd0) ? inst_rdata : data_rdata, rd);
      @(negedge clk);
      d_rvalid = 0; d_rresp = 0;
      #1;
      chk({tag, "_done"}, {rready, inst_data_ok, data_data_ok}, 3'b000);
   endtask

   // Transaction-level reference model for the random phase.
   logic        m_rd_busy, m_wr_busy, m_data_busy, m_last_inst, m_cur_inst;
   logic [31:0] m_cur_addr, m_w_addr, m_w_data;
   logic [2:0]  m_cur_size, m_w_size;
   logic [3:0]  m_w_strb;
   int          n_rd_done, n_wr_done;

   task automatic model_cycle();
      logic drd, dwr, dwin, exp_i, exp_drd, r_hs, b_hs;
      drd  = data_req && !data_wr && !m_data_busy && !m_rd_busy;
      dwr  = data_req && data_wr && !m_data_busy && !m_wr_busy;
`ifdef BRIDGE_DATA_PRIO_EN
      dwin = 1'b1;
`else
      dwin = !inst_req || m_last_inst;
`endif
      exp_drd = drd && dwin;
      exp_i   = inst_req && !m_rd_busy && !exp_drd;
      chk("rnd_inst_addr_ok", inst_addr_ok, exp_i);
      chk("rnd_data_addr_ok", data_addr_ok, exp_drd || dwr);
      r_hs = rvalid && rready;
      b_hs = bvalid && bready;
      if (arvalid && arready) begin
         chk("rnd_araddr", araddr, m_cur_addr);
         chk("rnd_arid_size", {arid, arsize}, {m_cur_inst ? 4'd0 : 4'd1, m_cur_size});
      end
      if (awvalid && awready)
         chk("rnd_aw", {awid, awsize, awaddr}, {4'd1, m_w_size, m_w_addr});
      if (wvalid && wready) begin
         chk("rnd_wdata", wdata, m_w_data);
         chk("rnd_wstrb_last", {wstrb, wlast}, {m_w_strb, 1'b1});
      end
      chk("rnd_data_ok", {inst_data_ok, data_data_ok},
          {r_hs && m_cur_inst, (r_hs && !m_cur_inst) || b_hs});
      if (r_hs) begin
         chk("rnd_rdata", m_cur_inst ? inst_rdata : data_rdata, m_cur_addr ^ RD_XOR);
         m_rd_busy = 0;
         if (!m_cur_inst) m_data_busy = 0;
         n_rd_done++;
      end
      if (b_hs) begin
         m_wr_busy = 0; m_data_busy = 0;
         n_wr_done++;
      end
      if (exp_drd) begin
         m_rd_busy = 1; m_data_busy = 1; m_cur_inst = 0; m_last_inst = 0;
         m_cur_addr = data_addr; m_cur_size = {1'b0, data_size[1:0]};
      end else if (exp_i) begin
         m_rd_busy = 1; m_cur_inst = 1; m_last_inst = 1;
         m_cur_addr = inst_addr; m_cur_size = 3'd2;
      end
      if (dwr) begin
         m_wr_busy = 1; m_data_busy = 1;
         m_w_addr = data_addr; m_w_size = {1'b0, data_size[1:0]};
         m_w_data = data_wdata; m_w_strb = data_wstrb;
      end
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "timeout");
   end

   initial begin
      // Reset state
      repeat (2) @(negedge clk);
      #1;
      chk("reset_valids", {arvalid, awvalid, wvalid, rready, bready}, 5'b0);
      chk("reset_regs", araddr | awaddr | wdata, 32'd0);
      @(negedge clk);
      resetn = 1;

      // Single inst read
      @(negedge clk);
      inst_req = 1; inst_addr = 32'hBFC0_0000;
      #1;
      chk("inst_rd_addr_ok", {inst_addr_ok, data_addr_ok}, 2'b10);
      serve_read(4'd0, 32'hBFC0_0000, 3'd2, 32'h3C01_0001, 2'b00, "inst_rd");

      // Data write, AW accepted one cycle before W
      @(negedge clk);
      data_req = 1; data_wr = 1; data_addr = 32'h8000_0010; data_wstrb = 4'b0011;
      data_size = 3'd1; data_wdata = 32'h1122_3344;
      #1;
      chk("wr_addr_ok", data_addr_ok, 1);
      @(negedge clk);
      data_req = 0; d_awready = 1;
      #1;
      chk("wr_valids", {awvalid, wvalid, bready}, 3'b110);
      chk("wr_aw", {awid, awsize, awlen, awburst}, {4'd1, 3'd1, 8'd0, 2'b01});
      chk("wr_awaddr", awaddr, 32'h8000_0010);
      chk("wr_wdata", wdata, 32'h1122_3344);
      chk("wr_wstrb_last", {wstrb, wlast}, {4'b0011, 1'b1});
      @(negedge clk);
      d_awready = 0; d_wready = 1;
      #1;
      chk("wr_aw_dropped", {awvalid, wvalid, bready}, 3'b010);
      @(negedge clk);
      d_wready = 0; d_bvalid = 1; d_bid = 4'd1;
      #1;
      chk("wr_bready", {awvalid, wvalid, bready}, 3'b001);
      chk("wr_data_ok", {data_data_ok, inst_data_ok}, 2'b10);
      @(negedge clk);
      d_bvalid = 0;
      #1;
      chk("wr_done", {bready, data_data_ok}, 2'b00);

      // Arbitration after an inst grant: data wins in either mode; slave error response
      @(negedge clk);
      inst_req = 1; inst_addr = 32'hBFC0_0010;
      data_req = 1; data_wr = 0; data_addr = 32'h8000_1000; data_size = 3'd0;
      #1;
      chk("arb1", {inst_addr_ok, data_addr_ok}, 2'b01);
      serve_read(4'd1, 32'h8000_1000, 3'd0, 32'hCAFE_F00D, 2'b10, "data_rd_slverr");

      // Tie again, this time after a data grant
      @(negedge clk);
      inst_req = 1; data_req = 1; data_wr = 0; data_addr = 32'h8000_2000; data_size = 3'd2;
      #1;
`ifdef BRIDGE_DATA_PRIO_EN
      chk("arb2", {inst_addr_ok, data_addr_ok}, 2'b01);
      serve_read(4'd1, 32'h8000_2000, 3'd2, 32'h0000_0042, 2'b00, "arb2_rd");
`else
      chk("arb2", {inst_addr_ok, data_addr_ok}, 2'b10);
      serve_read(4'd0, 32'hBFC0_0010, 3'd2, 32'h0000_0042, 2'b00, "arb2_rd");
`endif

      // Write + inst accepted together; inst completes under the write; data read waits for B
      @(negedge clk);
      data_req = 1; data_wr = 1; data_addr = 32'h8000_0020; data_size = 3'd2;
      data_wstrb = 4'hF; data_wdata = 32'hDEAD_BEEF;
      inst_req = 1; inst_addr = 32'hBFC0_0020;
      #1;
      chk("both_accept", {inst_addr_ok, data_addr_ok}, 2'b11);
      @(negedge clk);
      data_wr = 0; data_addr = 32'h8000_0030; inst_req = 0;
      d_arready = 1; d_awready = 1; d_wready = 1;
      #1;
      chk("busy_block0", data_addr_ok, 0);
      chk("both_valids", {arvalid, awvalid, wvalid}, 3'b111);
      @(negedge clk);
      d_arready = 0; d_awready = 0; d_wready = 0;
      d_rvalid = 1; d_rid = 4'd0; d_rdata = 32'h2402_0005;
      #1;
      chk("aw_w_same_cycle", {awvalid, wvalid, bready}, 3'b001);
      chk("inst_under_wr", {inst_data_ok, data_data_ok, data_addr_ok}, 3'b100);
      chk("inst_under_wr_rdata", inst_rdata, 32'h2402_0005);
      @(negedge clk);
      d_rvalid = 0; d_bvalid = 1; d_bid = 4'd1;
      #1;
      chk("b_cycle", {data_data_ok, data_addr_ok}, 2'b10);
      @(negedge clk);
      d_bvalid = 0;
      #1;
      chk("after_b_accept", data_addr_ok, 1);
      serve_read(4'd1, 32'h8000_0030, 3'd2, 32'h0BAD_CAFE, 2'b00, "rd_after_wr");

      // Reset while waiting for R
      @(negedge clk);
      inst_req = 1; inst_addr = 32'hBFC0_0100;
      #1;
      chk("pre_rst_accept", inst_addr_ok, 1);
      @(negedge clk);
      inst_req = 0; d_arready = 1;
      @(negedge clk);
      d_arready = 0;
      #1;
      chk("in_r_r", rready, 1);
      resetn = 0;
      #1;
      chk("async_rst", {rready, arvalid, awvalid, wvalid, bready}, 5'b0);
      @(negedge clk);
      resetn = 1;
      @(negedge clk);
      inst_req = 1; inst_addr = 32'hBFC0_0200;
      #1;
      chk("post_rst_accept", inst_addr_ok, 1);
      serve_read(4'd0, 32'hBFC0_0200, 3'd2, 32'h1234_5678, 2'b00, "post_rst_rd");

      // Randomized traffic against the reference model
      @(negedge clk);
      resetn = 0;
      @(negedge clk);
      resetn = 1; auto_en = 1;
      m_rd_busy = 0; m_wr_busy = 0; m_data_busy = 0; m_last_inst = 1; m_cur_inst = 0;
      m_cur_addr = 0; m_cur_size = 0; m_w_addr = 0; m_w_size = 0; m_w_data = 0; m_w_strb = 0;
      n_rd_done = 0; n_wr_done = 0;
      for (int i = 0; i < 3000; i++) begin
         @(negedge clk);
         inst_req   = 1'($urandom_range(0, 1));
         inst_addr  = $urandom;
         data_req   = 1'($urandom_range(0, 1));
         data_wr    = 1'($urandom_range(0, 1));
         data_addr  = $urandom;
         data_size  = 3'($urandom_range(0, 2));
         data_wstrb = 4'($urandom);
         data_wdata = $urandom;
         #1;
         model_cycle();
      end
      inst_req = 0; data_req = 0;
      for (int i = 0; i < 300 && (m_rd_busy || m_wr_busy); i++) begin
         @(negedge clk);
         #1;
         model_cycle();
      end
      chk("drain_idle", {m_rd_busy, m_wr_busy}, 2'b00);
      chk("rnd_activity", (n_rd_done > 50) && (n_wr_done > 20), 1);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
`default_nettype wire
